lw_sha_msg_schedule: RTL

- Message-schedule generator feeding the SHA compression round datapath; produces W[t] plus round index per round.
- Accepts one 16-word padded block over a valid/ready input stream, expands it to 64 words (SHA-256) or 80 words (SHA-512) and emits them in order over a valid/ready output stream.
- Sits between the block-input buffer and the round controller that drives the round's word/round_index inputs.

---
 rtl/lw_sha_msg_schedule.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lw_sha_msg_schedule.sv
// ---------------------------------------------------------------------------
// lw_sha_msg_schedule : SHA-256/512 message schedule, 16-word window -> W[t]
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lw_sha_msg_schedule #(
  parameter int WORD_SIZE   = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [WORD_SIZE-1:0] msg_word_i,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  output logic [WORD_SIZE-1:0] word_o,
  output logic [6:0]           round_index_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] w [BLOCK_WORDS];
  logic [3:0]           load_cnt;
  logic [6:0]           t;
  logic                 mode;
  logic                 ready_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  logic [31:0]          sum256;
  logic [63:0]          sum512;
  logic [WORD_SIZE-1:0] next_w;
  logic [WORD_SIZE-1:0] load_w;
  logic [6:0]           last_t;

  // Window holds W[t..t+15]; the new tail word is W[t+16].
  always_comb begin
    sum256 = sig1_256(w[14][31:0]) + w[9][31:0] + sig0_256(w[1][31:0]) + w[0][31:0];
    sum512 = sig1_512(w[14]) + w[9] + sig0_512(w[1]) + w[0];
    next_w = mode ? sum512 : {{(WORD_SIZE-32){1'b0}}, sum256};
    load_w = mode ? msg_word_i : {{(WORD_SIZE-32){1'b0}}, msg_word_i[31:0]};
    last_t = mode ? 7'd79 : 7'd63;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      load_cnt <= 4'd0;
      t        <= 7'd0;
      mode     <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            mode     <= mode_i;
            load_cnt <= 4'd0;
            t        <= 7'd0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (msg_valid_i) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) w[i] <= w[i+1];
            w[BLOCK_WORDS-1] <= load_w;
            load_cnt         <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              t       <= 7'd0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (word_ready_i) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) w[i] <= w[i+1];
            w[BLOCK_WORDS-1] <= next_w;
            t                <= t + 7'd1;
            if (t == last_t) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign msg_ready_o   = ready_q;
  assign word_valid_o  = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign word_o        = w[0];
  assign round_index_o = t;

endmodule

`default_nettype wire
